// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode/pipeline side bundle of the hazard scoreboard.
// master drives advance/flush/id_*; slave returns stall, fwd_a/b, busy, stall_cnt.
interface hazard_scoreboard_if #(
  parameter int FW = 2
);
  logic          advance;
  logic          flush;
  logic          id_valid;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic          id_regwr;
  logic [4:0]    id_wsel;
  logic          id_isload;
  logic          stall;
  logic [FW-1:0] fwd_a;
  logic [FW-1:0] fwd_b;
  logic          busy;
  logic [15:0]   stall_cnt;

  modport master (
    output advance, flush, id_valid, id_rs, id_rt,
    output id_uses_rs, id_uses_rt, id_regwr, id_wsel, id_isload,
    input  stall, fwd_a, fwd_b, busy, stall_cnt
  );

  modport slave (
    input  advance, flush, id_valid, id_rs, id_rt,
    input  id_uses_rs, id_uses_rt, id_regwr, id_wsel, id_isload,
    output stall, fwd_a, fwd_b, busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writer record, RAW/load-use stall, fwd selects.
// Ports: CLK, nRST (async low), bus (slave). Macro HAZARD_SCOREBOARD_FORWARD_EN.
module hazard_scoreboard #(
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int KILL       = 1,
  parameter int FW         = $clog2(STAGES + 1)
) (
  input logic               CLK,
  input logic               nRST,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] wsel;
    logic       isload;
  } entry_t;

  entry_t      ent [STAGES];
  entry_t      ins;
  logic        hit_a;
  logic        hit_b;
  logic        haz_a;
  logic        haz_b;
  logic        stall;
  logic        busy;
  logic [15:0] cnt;

  function automatic logic hits(
    input entry_t     e,
    input logic [4:0] s,
    input logic       use_s
  );
    return use_s && (s != 5'd0) && e.valid && (e.wsel == s);
  endfunction

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
  logic [FW-1:0] idx_a;
  logic [FW-1:0] idx_b;
  logic          ld_a;
  logic          ld_b;
  logic [FW-1:0] fwd_a_q;
  logic [FW-1:0] fwd_b_q;
`endif

  // Scan oldest to youngest so the youngest match is the last one kept.
  // The WB entry is skipped: the register file writes before it reads.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    idx_a = '0;
    idx_b = '0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
`endif
    for (int i = STAGES - 2; i >= 0; i--) begin
      if (hits(ent[i], bus.id_rs, bus.id_uses_rs)) begin
        hit_a = 1'b1;
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
        idx_a = FW'(i);
        ld_a  = ent[i].isload;
`endif
      end
      if (hits(ent[i], bus.id_rt, bus.id_uses_rt)) begin
        hit_b = 1'b1;
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
        idx_b = FW'(i);
        ld_b  = ent[i].isload;
`endif
      end
    end
  end

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
  // Producer sits at i+1 when the consumer reaches EX.
  assign haz_a = hit_a && ld_a && (int'(idx_a) + 1 < LOAD_STAGE);
  assign haz_b = hit_b && ld_b && (int'(idx_b) + 1 < LOAD_STAGE);
`else
  assign haz_a = hit_a;
  assign haz_b = hit_b;
`endif

  assign stall = bus.id_valid && !bus.flush && (haz_a || haz_b);

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      busy = busy | ent[i].valid;
    end
  end

  always_comb begin
    ins.valid  = bus.id_valid && bus.id_regwr && (bus.id_wsel != 5'd0)
                 && !bus.flush && !stall;
    ins.wsel   = bus.id_wsel;
    ins.isload = bus.id_isload;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < STAGES; k++) begin
        ent[k] <= '0;
      end
      cnt <= '0;
    end else if (bus.advance) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        ent[k] <= ent[k-1];
      end
      ent[0] <= ins;
      // Kill the younger in-flight work after the shift.
      if (bus.flush) begin
        for (int k = 1; k <= KILL; k++) begin
          ent[k].valid <= 1'b0;
        end
      end
      if (stall && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
  // Select k means the result in entry[k-1] once the consumer is in EX.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else if (bus.advance) begin
      if (bus.flush || stall || !bus.id_valid) begin
        fwd_a_q <= '0;
        fwd_b_q <= '0;
      end else begin
        fwd_a_q <= hit_a ? idx_a + FW'(2) : '0;
        fwd_b_q <= hit_b ? idx_b + FW'(2) : '0;
      end
    end
  end

  assign bus.fwd_a = fwd_a_q;
  assign bus.fwd_b = fwd_b_q;
`else
  assign bus.fwd_a = '0;
  assign bus.fwd_b = '0;
`endif

  assign bus.stall     = stall;
  assign bus.busy      = busy;
  assign bus.stall_cnt = cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of the hazard scoreboard,
// plus a deep instance driven into stall counter saturation.
module tb_hazard_scoreboard;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   exp_cnt;
  int   seen;

  hazard_scoreboard_if #(.FW(2)) bus ();
  hazard_scoreboard_if #(.FW(6)) sbus ();

  hazard_scoreboard #(
    .STAGES(3), .LOAD_STAGE(2), .KILL(1)
  ) dut (
    .CLK(clk), .nRST(rst_n), .bus(bus)
  );

  hazard_scoreboard #(
    .STAGES(32), .LOAD_STAGE(31), .KILL(1)
  ) sat (
    .CLK(clk), .nRST(rst_n), .bus(sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs,
                        input logic urt, input logic wr,
                        input logic [4:0] ws, input logic ld);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_regwr   = wr;
    bus.id_wsel    = ws;
    bus.id_isload  = ld;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.advance = 1'b1;
    bus.flush   = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    exp_cnt = 0;
    rst_n   = 1'b1;
    bus.advance = 1'b0;
    bus.flush   = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    sbus.advance    = 1'b0;
    sbus.flush      = 1'b0;
    sbus.id_valid   = 1'b0;
    sbus.id_rs      = 5'd3;
    sbus.id_rt      = 5'd0;
    sbus.id_uses_rs = 1'b1;
    sbus.id_uses_rt = 1'b0;
    sbus.id_regwr   = 1'b1;
    sbus.id_wsel    = 5'd3;
    sbus.id_isload  = 1'b1;
    #2 rst_n = 1'b0;

    // Reset held with random decode traffic.
    repeat (6) begin
      set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      bus.advance = 1'($urandom);
      bus.flush   = 1'($urandom);
      tick();
    end
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fwd_a", bus.fwd_a, 0);
    chk("rst_fwd_b", bus.fwd_b, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.advance = 1'b1;
    bus.flush   = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", bus.busy, 0);

    // ALU RAW
    drain();
    set_id(1, 1, 2, 1, 1, 1, 3, 0);
    #1 chk("alu1_stall", bus.stall, 0);
    tick();
    chk("alu1_busy", bus.busy, 1);
    set_id(1, 3, 3, 1, 1, 1, 4, 0);
    #1;
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    chk("raw_stall", bus.stall, 0);
    tick();
    chk("raw_fwd_a", bus.fwd_a, 2);
    chk("raw_fwd_b", bus.fwd_b, 2);
    set_id(1, 3, 0, 1, 1, 1, 6, 0);
    #1 chk("gap_stall", bus.stall, 0);
    tick();
    chk("gap_fwd_a", bus.fwd_a, 3);
    chk("gap_fwd_b", bus.fwd_b, 0);
`else
    chk("raw_stall0", bus.stall, 1);
    tick();
    exp_cnt++;
    chk("raw_stall1", bus.stall, 1);
    chk("raw_fwd_a0", bus.fwd_a, 0);
    tick();
    exp_cnt++;
    chk("raw_stall2", bus.stall, 0);
    tick();
    chk("raw_fwd_a", bus.fwd_a, 0);
    chk("raw_cnt", bus.stall_cnt, exp_cnt);
`endif

    // Load-use
    drain();
    set_id(1, 1, 0, 1, 0, 1, 5, 1);
    tick();
    set_id(1, 2, 5, 1, 1, 0, 0, 0);
    #1 chk("lu_stall", bus.stall, 1);
    bus.advance = 1'b0;
    tick();
    chk("lu_hold_stall", bus.stall, 1);
    chk("lu_hold_cnt", bus.stall_cnt, exp_cnt);
    bus.advance = 1'b1;
    tick();
    exp_cnt++;
    chk("lu_cnt", bus.stall_cnt, exp_cnt);
    chk("lu_bubble_fwd", bus.fwd_b, 0);
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    chk("lu_stall_done", bus.stall, 0);
    tick();
    chk("lu_fwd_b", bus.fwd_b, 3);
    chk("lu_fwd_a", bus.fwd_a, 0);
`else
    chk("lu_stall_more", bus.stall, 1);
    tick();
    exp_cnt++;
    chk("lu_stall_done", bus.stall, 0);
    tick();
    chk("lu_fwd_b", bus.fwd_b, 0);
    chk("lu_cnt2", bus.stall_cnt, exp_cnt);
`endif

    // Youngest writer wins
    drain();
    set_id(1, 1, 2, 1, 1, 1, 7, 0);
    tick();
    set_id(1, 1, 0, 1, 0, 1, 7, 0);
    tick();
    set_id(1, 7, 0, 1, 1, 1, 8, 0);
    #1;
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    chk("yw_stall", bus.stall, 0);
    tick();
    chk("yw_fwd_a", bus.fwd_a, 2);
    chk("yw_fwd_b", bus.fwd_b, 0);
`else
    chk("yw_stall0", bus.stall, 1);
    tick();
    exp_cnt++;
    chk("yw_stall1", bus.stall, 1);
    tick();
    exp_cnt++;
    chk("yw_stall2", bus.stall, 0);
    tick();
    chk("yw_fwd_a", bus.fwd_a, 0);
`endif
    set_id(1, 1, 2, 1, 1, 1, 0, 1);
    tick();
    set_id(1, 0, 0, 1, 1, 1, 9, 0);
    #1 chk("r0_stall", bus.stall, 0);
    tick();
    chk("r0_fwd_a", bus.fwd_a, 0);
    chk("r0_fwd_b", bus.fwd_b, 0);
    chk("yw_cnt", bus.stall_cnt, exp_cnt);

    // Flush
    drain();
    set_id(1, 1, 0, 1, 0, 1, 4, 1);
    tick();
    set_id(1, 4, 0, 1, 0, 1, 9, 0);
    #1 chk("fl_pre_stall", bus.stall, 1);
    bus.flush   = 1'b1;
    bus.advance = 1'b0;
    #1 chk("fl_stall", bus.stall, 0);
    tick();
    chk("fl_noadv_busy", bus.busy, 1);
    bus.advance = 1'b1;
    tick();
    chk("fl_busy", bus.busy, 0);
    chk("fl_fwd_a", bus.fwd_a, 0);
    chk("fl_cnt", bus.stall_cnt, exp_cnt);
    bus.flush = 1'b0;
    #1 chk("fl_after_stall", bus.stall, 0);

    // Asynchronous reset mid-operation
    set_id(1, 1, 2, 1, 1, 1, 3, 0);
    tick();
    chk("ar_busy_pre", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_cnt", bus.stall_cnt, 0);
    exp_cnt = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Saturation on the deep instance: a self-dependent load
    sbus.id_valid = 1'b1;
    sbus.advance  = 1'b1;
    for (int c = 0; c < 80000; c++) begin
      if (sbus.stall_cnt == 16'hFFFF) break;
      tick();
    end
    chk("sat_reach", sbus.stall_cnt, 32'hFFFF);
    seen = 0;
    repeat (64) begin
      if (sbus.stall) seen++;
      tick();
    end
    chk("sat_stalls_seen", 32'(seen != 0), 1);
    chk("sat_hold", sbus.stall_cnt, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Parametrised hazard-tracking block for the pipelined MIPS datapath.
- Holds a shift record of in-flight register writers, one entry per pipeline stage past decode.
- For the instruction in decode it produces:
  - a load-use / RAW stall,
  - registered forwarding selects that the EX operand muxes consume one cycle later,
  - a saturating stall performance counter.
- Generalises the fixed 5-stage hazard logic to any tracked depth, load-data latency and flush depth.

## Interface
Parameters:
- STAGES, 3, tracked entries after decode; entry[0]=EX, entry[STAGES-1]=WB
- LOAD_STAGE, 2, lowest entry index at which a load result is forwardable (1..STAGES-1)
- KILL, 1, number of entries, counted from entry[0], invalidated by flush (0..STAGES-1)
- FW, $clog2(STAGES+1), width of forwarding selects

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- advance  in  1  pipeline moves this cycle (ihit && !dhit)
- flush  in  1  branch/jump resolved taken; kill decode and younger in-flight work
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt  in  5  source registers of decode instruction
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_regwr  in  1  decode instruction writes a register
- id_wsel  in  5  its destination
- id_isload  in  1  its result comes from memory
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX (combinational)
- fwd_a, fwd_b  out  FW  EX operand select: 0=ID/EX register value, k=result held in entry[k-1]
- busy  out  1  any entry valid
- stall_cnt  out  16  count of advancing stall cycles, saturating

Clock is CLK; reset is asynchronous, active-low, named nRST.

## Operation
- Entry = {valid, wsel, isload}.
  - Insertion requires id_regwr=1 and id_wsel!=0; otherwise the inserted entry is invalid.
- Match for a used source s (s!=0): valid entry i in 0..STAGES-2 with wsel==s.
  - The youngest match (lowest i) wins.
  - Entry STAGES-1 is never matched; the register file is write-before-read.
- Hazard (FORWARD_EN):
  - A source's youngest match is a load at i with i+1 < LOAD_STAGE.
  - The producer's position when the consumer reaches EX is i+1.
- stall = id_valid && !flush && hazard(rs || rt).
- On advance=1, all entries shift up one; entry[STAGES-1] is discarded.
  - flush=1: new entry[0] invalid; entries 1..KILL (post-shift) invalid; fwd_a/fwd_b <= 0.
  - else stall=1: new entry[0] invalid (bubble); fwd_a/fwd_b <= 0; stall_cnt += 1, saturating at 0xFFFF.
  - else: new entry[0] from decode.
    - fwd_x <= i+2 for the youngest match of that source, or 0 if none or unused.
    - fwd_x is never computed from an inserted bubble.
- advance=0: entries, fwd regs and stall_cnt hold. stall remains combinational from current state.
- flush with advance=0 has no effect; the requester holds flush until advance.
- Simultaneous flush and hazard: flush wins; stall=0.

## Timing
- Reset (async): all entries invalid, fwd_a=fwd_b=0, stall_cnt=0.
  - Hence stall=0 and busy=0.
- stall: zero-latency combinational from id_* and entry state.
- fwd_a/fwd_b: registered.
  - Valid in the cycle after the issuing advance, aligned with the instruction in EX.
- Load-use with defaults: exactly 1 stall cycle.
- nRST mid-operation clears state immediately, independent of CLK.

## Configuration
- HAZARD_SCOREBOARD_FORWARD_EN defined:
  - Forwarding as above.
  - Only load-use below LOAD_STAGE stalls.
- Undefined:
  - fwd_a/fwd_b tied to 0.
  - Hazard = any match in entries 0..STAGES-2, regardless of isload.
  - A back-to-back dependency stalls STAGES-1 cycles.

## Test plan
- Reset: hold nRST=0 with random inputs -> stall=0, busy=0, fwd_a=fwd_b=0, stall_cnt=0. After release, busy=0 until first insertion.
- ALU RAW (FORWARD_EN):
  - Issue add r3, then add r4,r3,r3 -> stall=0; next cycle fwd_a=fwd_b=2.
  - With one independent instruction between -> fwd_a=3.
- Load-use:
  - lw r5, then sw using r5 as rt -> stall=1 for one advancing cycle, bubble inserted, then issue with fwd_b=3; stall_cnt=1.
  - advance=0 during stall -> stall stays 1, stall_cnt unchanged.
- Youngest wins: writers to r7 at entry[1] and entry[0], consumer reads r7 -> fwd_a=2 after issue. Source r0 always gives fwd=0, no stall.
- Flush: lw r4 in entry[0], consumer of r4 in decode, flush=1, advance=1 -> stall=0, entries 0..1 invalid, fwd_a=0, stall_cnt unchanged.
- Macro off: add r3 then consumer of r3 -> stall for 2 advancing cycles, fwd 0 throughout, stall_cnt=2. Force 0x10000 stalls -> stall_cnt holds 0xFFFF.
